// File: rtl/list_fetch.sv
// list_fetch: walks a singly linked list in word-addressed memory from a head
// pointer and emits one FS-word packet (header + node payload) per node.
module list_fetch #(
  parameter int DW        = 32,
  parameter int AW        = 16,
  parameter int FS        = 4,
  parameter int MAX_NODES = 256
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [AW-1:0]         head_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [AW-1:0]         mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DW-1:0]         mem_rsp_data,
  output logic [FS-1:0][DW-1:0] OUT,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CW = $clog2(FS + 1);
  localparam int NW = $clog2(MAX_NODES + 1);
  localparam logic [CW-1:0] FS_CNT    = CW'(FS);
  localparam logic [CW-1:0] FS_LAST   = CW'(FS - 1);
  localparam logic [NW-1:0] NODE_LAST = NW'(MAX_NODES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] cur_addr;
  logic [CW-1:0] req_cnt;
  logic [CW-1:0] rsp_cnt;
  logic          armed;
  logic [DW-1:0] next_ptr;
  logic [NW-1:0] node_cnt;
  logic          req_fire;
  logic          rsp_take;
  logic          hdr_last;
  logic          hdr_trip;
  logic [DW-1:0] hdr_word;

  // The first FETCH cycle is a bubble (armed=0); the distance between
  // req_cnt and rsp_cnt is the number of responses still owed to us.
  always_comb begin
    busy          = (state == S_FETCH) || (state == S_EMIT);
    done          = (state == S_FIN);
    out_valid     = (state == S_EMIT);
    mem_req_valid = (state == S_FETCH) && armed && (req_cnt != FS_CNT);
    mem_req_addr  = mem_req_valid ? cur_addr + AW'(req_cnt) : '0;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_take      = (state == S_FETCH) && mem_rsp_valid && (rsp_cnt != req_cnt);
    hdr_last      = (next_ptr == '0);
    hdr_trip      = !hdr_last && (node_cnt == NODE_LAST);
    hdr_word      = '0;
    hdr_word[0]   = 1'b1;
    hdr_word[1]   = hdr_last;
    hdr_word[2]   = hdr_trip;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      cur_addr <= '0;
      req_cnt  <= '0;
      rsp_cnt  <= '0;
      armed    <= 1'b0;
      next_ptr <= '0;
      node_cnt <= '0;
      err      <= 1'b0;
      OUT      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr <= head_addr;
            err      <= 1'b0;
            node_cnt <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            armed    <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // An empty list is detected in the bubble cycle, before any request.
          if (!armed) begin
            if (node_cnt == '0 && cur_addr == '0) state <= S_FIN;
            else                                  armed <= 1'b1;
          end
          if (req_fire) req_cnt <= req_cnt + 1'b1;
          if (rsp_take) begin
            rsp_cnt <= rsp_cnt + 1'b1;
            if (rsp_cnt == '0) next_ptr <= mem_rsp_data;
            for (int k = 1; k < FS; k++) begin
              if (rsp_cnt == CW'(k)) OUT[k] <= mem_rsp_data;
            end
            if (rsp_cnt == FS_LAST) begin
              OUT[0] <= hdr_word;
              state  <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          // The header already encodes where the walk goes next.
          if (out_ready) begin
            node_cnt <= node_cnt + 1'b1;
            if (OUT[0][1]) begin
              state <= S_FIN;
            end else if (OUT[0][2]) begin
              err   <= 1'b1;
              state <= S_FIN;
            end else begin
              cur_addr <= next_ptr[AW-1:0];
              req_cnt  <= '0;
              rsp_cnt  <= '0;
              armed    <= 1'b0;
              state    <= S_FETCH;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_list_fetch.sv
// Testbench for list_fetch: behavioural memory slave plus a list-walking
// reference model; each test task drives a scenario and checks it inline.
module tb_list_fetch;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int FS   = 4;
  localparam int MAXN = 4;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  start;
  logic [AW-1:0]         head_addr;
  logic                  busy, done, err;
  logic                  mem_req_valid, mem_req_ready;
  logic [AW-1:0]         mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DW-1:0]         mem_rsp_data;
  logic [FS-1:0][DW-1:0] OUT;
  logic                  out_valid, out_ready;

  always #5 CLK = ~CLK;

  list_fetch #(.DW(DW), .AW(AW), .FS(FS), .MAX_NODES(MAXN)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .head_addr(head_addr),
    .busy(busy), .done(done), .err(err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .OUT(OUT), .out_valid(out_valid), .out_ready(out_ready)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0]      mem [0:65535];
  int                 due_q[$];
  logic [DW-1:0]      data_q[$];
  int                 rsp_lat    = 1;
  int                 ready_mode = 0;
  int                 stall_len  = 0;
  bit                 spurious   = 1'b0;

  logic [AW-1:0]      req_log[$];
  logic [FS*DW-1:0]   pkt_log[$];
  int                 accept_log[$];
  int                 done_log[$];
  int                 first_req_cyc;
  int                 emit_req_cnt;
  int                 unstable_cnt;
  int                 done_busy_cnt;
  logic               err_at_done;
  int                 stall_cnt = 0;
  logic [FS*DW-1:0]   snap;
  bit                 snap_ok = 1'b0;

  logic [FS*DW-1:0]   exp_pkts[$];
  logic [AW-1:0]      exp_addrs[$];
  logic               exp_err;
  logic [AW-1:0]      list_head;

  // Memory slave, downstream sink and observation logs, all acting mid-cycle.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    out_ready     = 1'b0;
    forever begin
      @(negedge CLK);
      case (ready_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = ((cyc % 2) == 0);
        default: mem_req_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        mem_rsp_valid = spurious && (due_q.size() == 0) && ($urandom_range(0, 1) == 1);
        mem_rsp_data  = $urandom;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (req_log.size() == 0) first_req_cyc = cyc;
        req_log.push_back(mem_req_addr);
        due_q.push_back(cyc + rsp_lat);
        data_q.push_back(mem[mem_req_addr]);
      end
      if (mem_req_valid && out_valid) emit_req_cnt++;
      if (done) begin
        done_log.push_back(cyc);
        err_at_done = err;
        if (busy) done_busy_cnt++;
      end
      if (out_valid) begin
        if (snap_ok && OUT !== snap) unstable_cnt++;
        if (stall_cnt < stall_len) begin
          out_ready = 1'b0;
          stall_cnt++;
          snap    = OUT;
          snap_ok = 1'b1;
        end else begin
          out_ready = 1'b1;
          pkt_log.push_back(OUT);
          accept_log.push_back(cyc);
          stall_cnt = 0;
          snap_ok   = 1'b0;
        end
      end else begin
        out_ready = ($urandom_range(0, 1) == 1);
        snap_ok   = 1'b0;
      end
    end
  end

  // Reference walk over the memory image: packets, request addresses, err.
  task automatic build_expect(input logic [AW-1:0] head);
    logic [AW-1:0]    a;
    logic [AW-1:0]    ak;
    logic [DW-1:0]    nxt;
    logic [FS*DW-1:0] p;
    logic             last, trip;
    int               n;
    exp_pkts.delete();
    exp_addrs.delete();
    exp_err = 1'b0;
    a = head;
    n = 0;
    while (a != '0 || n > 0) begin
      nxt = mem[a];
      p   = '0;
      for (int k = 0; k < FS; k++) begin
        ak = a + AW'(k);
        exp_addrs.push_back(ak);
        if (k > 0) p[k*DW +: DW] = mem[ak];
      end
      n++;
      last = (nxt == '0);
      trip = !last && (n == MAXN);
      p[DW-1:0] = DW'(1) + (last ? DW'(2) : DW'(0)) + (trip ? DW'(4) : DW'(0));
      exp_pkts.push_back(p);
      if (last || trip) begin
        exp_err = trip;
        break;
      end
      a = nxt[AW-1:0];
    end
  endtask

  task automatic make_list(input int n, input bit loop_back);
    logic [AW-1:0] addrs[$];
    logic [AW-1:0] a;
    bit            dup;
    while (addrs.size() < n) begin
      a   = AW'($urandom_range(1, 8000) * 8);
      dup = 1'b0;
      foreach (addrs[i]) if (addrs[i] == a) dup = 1'b1;
      if (!dup) addrs.push_back(a);
    end
    for (int i = 0; i < n; i++) begin
      if (i < n - 1)      mem[addrs[i]] = DW'(addrs[i+1]);
      else if (loop_back) mem[addrs[i]] = DW'(addrs[0]);
      else                mem[addrs[i]] = '0;
      for (int k = 1; k < FS; k++) mem[AW'(addrs[i] + AW'(k))] = $urandom;
    end
    list_head = addrs[0];
  endtask

  task automatic clear_logs();
    req_log.delete();
    pkt_log.delete();
    accept_log.delete();
    done_log.delete();
    emit_req_cnt  = 0;
    unstable_cnt  = 0;
    done_busy_cnt = 0;
    first_req_cyc = -1;
    err_at_done   = 1'b0;
  endtask

  task automatic do_walk(input logic [AW-1:0] head, input bit poke, output int s_cyc, output bit tmo);
    int waited;
    clear_logs();
    @(negedge CLK);
    start     = 1'b1;
    head_addr = head;
    s_cyc     = cyc;
    @(negedge CLK);
    start     = 1'b0;
    head_addr = AW'($urandom);
    if (poke) begin
      repeat (2) @(negedge CLK);
      start     = 1'b1;
      head_addr = AW'($urandom_range(1, 65535));
      @(negedge CLK);
      start     = 1'b0;
    end
    waited = 0;
    while (done_log.size() == 0 && waited < 3000) begin
      @(negedge CLK);
      waited++;
    end
    tmo = (done_log.size() == 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    start = 1'b0;
    head_addr = '0;
    repeat (3) @(negedge CLK);
    compared++;
    if ({busy, done, err, mem_req_valid, out_valid} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, err, mem_req_valid, out_valid});
    end
    compared++;
    if (OUT !== '0 || mem_req_addr !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got OUT=%h addr=%h expected 0", OUT, mem_req_addr);
    end
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_list();
    int s; bit tmo; bit addr_ok;
    for (int i = 0; i < 3; i++) begin
      mem[AW'(16 * (i + 1))] = (i < 2) ? DW'(16 * (i + 2)) : '0;
      for (int k = 1; k < FS; k++) mem[AW'(16 * (i + 1) + k)] = DW'(3 * i + k);
    end
    rsp_lat = 1; ready_mode = 0; stall_len = 0; spurious = 1'b0;
    build_expect(16'h0010);
    do_walk(16'h0010, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    compared++;
    if (pkt_log.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL basic_count: got %0d packets expected 3", pkt_log.size());
    end else begin
      foreach (exp_pkts[i]) begin
        compared++;
        if (pkt_log[i] !== exp_pkts[i]) begin
          mismatched++;
          $display("[TB] FAIL basic_pkt%0d: got %h expected %h", i, pkt_log[i], exp_pkts[i]);
        end
      end
      compared++;
      if (pkt_log[2][DW-1:0] !== DW'(3) || pkt_log[1][2*DW +: DW] !== DW'(5)) begin
        mismatched++;
        $display("[TB] FAIL basic_hdr: got hdr=%h w2=%h expected 3 and 5", pkt_log[2][DW-1:0], pkt_log[1][2*DW +: DW]);
      end
    end
    addr_ok = (req_log.size() == exp_addrs.size());
    if (addr_ok) foreach (exp_addrs[i]) if (req_log[i] !== exp_addrs[i]) addr_ok = 1'b0;
    compared++;
    if (!addr_ok) begin mismatched++; $display("[TB] FAIL basic_addrs: got %0d requests expected %0d in order", req_log.size(), exp_addrs.size()); end
    compared++;
    if (first_req_cyc - s != 2) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 2", first_req_cyc - s); end
    if (accept_log.size() > 0 && done_log.size() > 0) begin
      compared++;
      if (done_log[0] != accept_log[$] + 1) begin
        mismatched++;
        $display("[TB] FAIL basic_done_time: got %0d expected %0d", done_log[0], accept_log[$] + 1);
      end
    end
    compared++;
    if (done_log.size() != 1 || done_busy_cnt != 0 || err_at_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got pulses=%0d busy=%0d err=%b expected 1/0/0", done_log.size(), done_busy_cnt, err_at_done);
    end
  endtask

  task automatic test_stall();
    int s; bit tmo; bit pkt_ok;
    rsp_lat = 2; ready_mode = 0; stall_len = 5; spurious = 1'b0;
    build_expect(16'h0010);
    do_walk(16'h0010, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL stall_timeout: got no done expected done"); end
    pkt_ok = (pkt_log.size() == exp_pkts.size());
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!pkt_ok) begin mismatched++; $display("[TB] FAIL stall_pkts: got %0d packets expected %0d matching", pkt_log.size(), exp_pkts.size()); end
    compared++;
    if (unstable_cnt != 0) begin mismatched++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", unstable_cnt); end
    compared++;
    if (emit_req_cnt != 0 || req_log.size() != exp_addrs.size()) begin
      mismatched++;
      $display("[TB] FAIL stall_reqs: got emit_reqs=%0d total=%0d expected 0/%0d", emit_req_cnt, req_log.size(), exp_addrs.size());
    end
  endtask

  task automatic test_mem_backpressure();
    int s; bit tmo; bit addr_ok; bit pkt_ok;
    rsp_lat = 3; ready_mode = 1; stall_len = 0; spurious = 1'b0;
    build_expect(16'h0010);
    do_walk(16'h0010, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL bp_timeout: got no done expected done"); end
    addr_ok = (req_log.size() == exp_addrs.size());
    if (addr_ok) foreach (exp_addrs[i]) if (req_log[i] !== exp_addrs[i]) addr_ok = 1'b0;
    compared++;
    if (!addr_ok) begin mismatched++; $display("[TB] FAIL bp_addrs: got %0d requests expected %0d in order", req_log.size(), exp_addrs.size()); end
    pkt_ok = (pkt_log.size() == exp_pkts.size());
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!pkt_ok) begin mismatched++; $display("[TB] FAIL bp_pkts: got %0d packets expected %0d matching", pkt_log.size(), exp_pkts.size()); end
  endtask

  task automatic test_loop_guard();
    int s; bit tmo; bit pkt_ok;
    mem[16'h0040] = DW'(16'h0040);
    for (int k = 1; k < FS; k++) mem[AW'(16'h0040 + k)] = DW'(32'hA0 + k);
    rsp_lat = 1; ready_mode = 0; stall_len = 1; spurious = 1'b0;
    build_expect(16'h0040);
    do_walk(16'h0040, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL loop_timeout: got no done expected done"); end
    pkt_ok = (pkt_log.size() == exp_pkts.size()) && (exp_pkts.size() == MAXN);
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!pkt_ok) begin mismatched++; $display("[TB] FAIL loop_pkts: got %0d packets expected %0d matching", pkt_log.size(), MAXN); end
    if (pkt_log.size() == MAXN) begin
      compared++;
      if (pkt_log[MAXN-1][DW-1:0] !== DW'(5)) begin
        mismatched++;
        $display("[TB] FAIL loop_hdr: got %h expected 5", pkt_log[MAXN-1][DW-1:0]);
      end
    end
    compared++;
    if (err_at_done !== 1'b1 || done_log.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL loop_done: got err=%b pulses=%0d expected 1/1", err_at_done, done_log.size());
    end
    repeat (5) @(negedge CLK);
    compared++;
    if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL loop_err_held: got %b expected 1", err); end
  endtask

  task automatic test_empty();
    int s; bit tmo;
    rsp_lat = 1; ready_mode = 0; stall_len = 0; spurious = 1'b0;
    do_walk('0, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL empty_timeout: got no done expected done"); end
    compared++;
    if (req_log.size() != 0 || pkt_log.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL empty_traffic: got reqs=%0d pkts=%0d expected 0/0", req_log.size(), pkt_log.size());
    end
    if (done_log.size() > 0) begin
      compared++;
      if (done_log[0] - s != 2) begin mismatched++; $display("[TB] FAIL empty_done_time: got %0d expected 2", done_log[0] - s); end
    end
    compared++;
    if (err_at_done !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL empty_err: got %b/%b expected 0/0", err_at_done, err);
    end
  endtask

  task automatic test_wrap();
    int s; bit tmo; bit addr_ok; bit pkt_ok;
    mem[16'hFFFE] = DW'(16'h0100);
    mem[16'hFFFF] = 32'h1111_0001;
    mem[16'h0000] = 32'h1111_0002;
    mem[16'h0001] = 32'h1111_0003;
    mem[16'h0100] = '0;
    for (int k = 1; k < FS; k++) mem[AW'(16'h0100 + k)] = DW'(32'h2222_0000 + k);
    rsp_lat = 2; ready_mode = 2; stall_len = 0; spurious = 1'b1;
    build_expect(16'hFFFE);
    do_walk(16'hFFFE, 1'b0, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL wrap_timeout: got no done expected done"); end
    addr_ok = (req_log.size() == exp_addrs.size());
    if (addr_ok) foreach (exp_addrs[i]) if (req_log[i] !== exp_addrs[i]) addr_ok = 1'b0;
    compared++;
    if (!addr_ok) begin mismatched++; $display("[TB] FAIL wrap_addrs: got %0d requests expected %0d in order", req_log.size(), exp_addrs.size()); end
    pkt_ok = (pkt_log.size() == exp_pkts.size());
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!pkt_ok) begin mismatched++; $display("[TB] FAIL wrap_pkts: got %0d packets expected %0d matching", pkt_log.size(), exp_pkts.size()); end
  endtask

  task automatic test_start_while_busy();
    int s; bit tmo; bit addr_ok; bit pkt_ok;
    make_list(3, 1'b0);
    rsp_lat = 2; ready_mode = 0; stall_len = 2; spurious = 1'b0;
    build_expect(list_head);
    do_walk(list_head, 1'b1, s, tmo);
    compared++;
    if (tmo) begin mismatched++; $display("[TB] FAIL busy_start_timeout: got no done expected done"); end
    addr_ok = (req_log.size() == exp_addrs.size());
    if (addr_ok) foreach (exp_addrs[i]) if (req_log[i] !== exp_addrs[i]) addr_ok = 1'b0;
    pkt_ok = (pkt_log.size() == exp_pkts.size());
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!addr_ok || !pkt_ok || done_log.size() != 1) begin
      mismatched++;
      $display("[TB] FAIL busy_start: got reqs=%0d pkts=%0d pulses=%0d expected %0d/%0d/1",
               req_log.size(), pkt_log.size(), done_log.size(), exp_addrs.size(), exp_pkts.size());
    end
  endtask

  task automatic test_reset_mid_walk();
    int s; bit tmo; int waited; bit pkt_ok;
    mem[16'h0200] = DW'(16'h0300);
    mem[16'h0300] = '0;
    for (int k = 1; k < FS; k++) begin
      mem[AW'(16'h0200 + k)] = $urandom;
      mem[AW'(16'h0300 + k)] = $urandom;
    end
    rsp_lat = 4; ready_mode = 0; stall_len = 0; spurious = 1'b0;
    clear_logs();
    @(negedge CLK);
    start = 1'b1; head_addr = 16'h0200;
    @(negedge CLK);
    start = 1'b0;
    waited = 0;
    while (req_log.size() < 2 && waited < 20) begin @(negedge CLK); waited++; end
    compared++;
    if (req_log.size() < 2) begin mismatched++; $display("[TB] FAIL rst_mid_reach: got %0d requests expected >=2", req_log.size()); end
    RESET = 1'b1;
    @(negedge CLK);
    compared++;
    if ({busy, done, err, mem_req_valid, out_valid} !== 5'b0 || OUT !== '0 || mem_req_addr !== '0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_outputs: got %b OUT=%h addr=%h expected all 0",
               {busy, done, err, mem_req_valid, out_valid}, OUT, mem_req_addr);
    end
    RESET = 1'b0;
    pkt_log.delete();
    repeat (10) @(negedge CLK);
    compared++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || pkt_log.size() != 0 || due_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_idle: got busy=%b valid=%b pkts=%0d pending=%0d expected 0/0/0/0",
               busy, out_valid, pkt_log.size(), due_q.size());
    end
    build_expect(16'h0200);
    do_walk(16'h0200, 1'b0, s, tmo);
    pkt_ok = !tmo && (pkt_log.size() == exp_pkts.size());
    if (pkt_ok) foreach (exp_pkts[i]) if (pkt_log[i] !== exp_pkts[i]) pkt_ok = 1'b0;
    compared++;
    if (!pkt_ok) begin mismatched++; $display("[TB] FAIL rst_mid_rewalk: got %0d packets timeout=%b expected %0d/0", pkt_log.size(), tmo, exp_pkts.size()); end
  endtask

  task automatic test_random();
    int s; bit tmo; bit addr_ok; int n;
    for (int it = 0; it < 16; it++) begin
      n = $urandom_range(1, 6);
      make_list(n, ($urandom_range(0, 1) == 1));
      rsp_lat = $urandom_range(1, 4);
      ready_mode = $urandom_range(0, 2);
      stall_len = $urandom_range(0, 3);
      spurious = ($urandom_range(0, 1) == 1);
      build_expect(list_head);
      do_walk(list_head, 1'b0, s, tmo);
      compared++;
      if (tmo) begin mismatched++; $display("[TB] FAIL rand%0d_timeout: got no done expected done", it); end
      compared++;
      if (pkt_log.size() != exp_pkts.size()) begin
        mismatched++;
        $display("[TB] FAIL rand%0d_count: got %0d packets expected %0d", it, pkt_log.size(), exp_pkts.size());
      end else begin
        foreach (exp_pkts[i]) begin
          compared++;
          if (pkt_log[i] !== exp_pkts[i]) begin
            mismatched++;
            $display("[TB] FAIL rand%0d_pkt%0d: got %h expected %h", it, i, pkt_log[i], exp_pkts[i]);
          end
        end
      end
      addr_ok = (req_log.size() == exp_addrs.size());
      if (addr_ok) foreach (exp_addrs[i]) if (req_log[i] !== exp_addrs[i]) addr_ok = 1'b0;
      compared++;
      if (!addr_ok) begin mismatched++; $display("[TB] FAIL rand%0d_addrs: got %0d requests expected %0d in order", it, req_log.size(), exp_addrs.size()); end
      compared++;
      if (err_at_done !== exp_err) begin mismatched++; $display("[TB] FAIL rand%0d_err: got %b expected %b", it, err_at_done, exp_err); end
      if (accept_log.size() > 0 && done_log.size() > 0) begin
        compared++;
        if (done_log[0] != accept_log[$] + 1 || unstable_cnt != 0) begin
          mismatched++;
          $display("[TB] FAIL rand%0d_done: got done=%0d unstable=%0d expected %0d/0", it, done_log[0], unstable_cnt, accept_log[$] + 1);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    head_addr = '0;
    test_reset();
    test_basic_list();
    test_stall();
    test_mem_backpressure();
    test_loop_guard();
    test_empty();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_walk();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
